// File: rtl/pipe_out_collector.sv
// pipe_out_collector: FWFT FIFO collecting pipeline results with accept/drop counters, sticky overflow and XOR checksum
module pipe_out_collector #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                accept_cnt,
    output logic [7:0]                 drop_cnt,
    output logic                       overflow,
    output logic [W-1:0]               checksum
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          pop, push, drop, full;
    always_comb begin
        full      = level == FULL;
        out_valid = level != '0;
        out_data  = mem[rd_ptr];
        pop       = out_valid & out_ready;
        push      = in_valid & (~full | pop);
        drop      = in_valid & full & ~pop;
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            accept_cnt <= '0;
            drop_cnt   <= '0;
            overflow   <= 1'b0;
            checksum   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push) - (AW+1)'(pop);
            if (push) accept_cnt <= accept_cnt + 16'd1;
            if (push) checksum <= checksum ^ in_data;
            if (drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
            if (drop) overflow <= 1'b1;
        end
    end
endmodule

// File: doc/pipe_out_collector.md
PIPE_OUT_COLLECTOR -- requirements
Module: pipe_out_collector

Interface
REQ-001 SHALL have parameter W, default 8, data width of one pipeline result.
REQ-002 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on rising clk.
REQ-005 SHALL have port in_valid, input, 1, upstream pipeline result valid (no backpressure upstream).
REQ-006 SHALL have port in_data, input, W, upstream pipeline result.
REQ-007 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts head.
REQ-009 SHALL have port out_data, output, W, FIFO head data.
REQ-010 SHALL have port level, output, clog2(DEPTH)+1, current occupancy.
REQ-011 SHALL have port accept_cnt, output, 16, count of accepted pushes.
REQ-012 SHALL have port drop_cnt, output, 8, count of dropped pushes.
REQ-013 SHALL have port overflow, output, 1, sticky drop indicator.
REQ-014 SHALL have port checksum, output, W, running XOR of accepted in_data.

Function
REQ-015 SHALL implement a first-word-fall-through FIFO: out_valid = (level != 0); out_data = oldest stored entry whenever out_valid.
REQ-016 SHALL define pop = out_valid & out_ready; pop removes head on that clock edge.
REQ-017 SHALL accept push when in_valid & (level < DEPTH | pop); accepted data is written at tail on that edge.
REQ-018 SHALL have no empty bypass: push into empty FIFO gives out_valid = 1 on the next cycle (latency 1), never the same cycle.
REQ-019 SHALL on simultaneous push and pop leave level unchanged, including at level = DEPTH (push accepted) and level = 1 (new entry becomes head).
REQ-020 SHALL wrap read/write pointers modulo DEPTH; data order strictly FIFO across wrap.
REQ-021 SHALL drop when in_valid & level = DEPTH & !pop: no write, FIFO content unchanged.
REQ-022 SHALL on drop increment drop_cnt, saturating at 255, and set overflow = 1; overflow stays 1 until reset.
REQ-023 SHALL increment accept_cnt by 1 per accepted push, wrapping 65535 -> 0.
REQ-024 SHALL update checksum <= checksum ^ in_data per accepted push; dropped data never enters checksum.
REQ-025 SHALL leave out_data content unspecified when out_valid = 0; out_ready while empty has no effect.
REQ-026 SHALL register level, accept_cnt, drop_cnt, overflow, checksum; all reflect the edge just taken.

Reset
REQ-027 SHALL, while rst_n = 0 at a rising edge, set level = 0, pointers = 0, out_valid = 0, accept_cnt = 0, drop_cnt = 0, overflow = 0, checksum = 0.
REQ-028 SHALL give reset priority over push/pop in the same cycle; in-flight FIFO contents discarded, no push counted.
REQ-029 SHALL require no reset on FIFO storage array.

Verification (W=8, DEPTH=4)
REQ-030 SHALL cover: push 0x11,0x22,0x33 with out_ready=0 -> level=3, out_data=0x11, checksum=0x00, accept_cnt=3.
REQ-031 SHALL cover: push 5 values 0x01..0x05 back-to-back, out_ready=0 -> level=4, drop_cnt=1, overflow=1, checksum=0x04, head 0x01.
REQ-032 SHALL cover: FIFO full, in_valid=1 and out_ready=1 same cycle -> level stays 4, no drop, accept_cnt+1.
REQ-033 SHALL cover: single push 0xA5 into empty with out_ready=1 -> out_valid=0 that cycle, 1 next cycle with 0xA5, then popped, level=0.
REQ-034 SHALL cover: 10 push/pop pairs across pointer wrap -> output order equals input order, level never exceeds 1.
REQ-035 SHALL cover: rst_n=0 mid-stream with level=3, overflow=1 -> next cycle all outputs 0, out_valid=0.
